// File: rtl/alu_regfile_exec_if.sv
// ============================================================================
// Module  : alu_regfile_exec_if
// Brief   : Issue/result bundle between decode and the execute block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_regfile_exec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  we;
    logic                  alu_src;
    logic [DATA_WIDTH-1:0] imm_op;
    logic [2:0]            alu_ctrl;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  eq;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output in_valid, rs1, rs2, rd, we, alu_src, imm_op, alu_ctrl,
        input  in_ready, out_valid, alu_out, eq, a0
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, we, alu_src, imm_op, alu_ctrl,
        output in_ready, out_valid, alu_out, eq, a0
    );
endinterface

`default_nettype wire

// File: rtl/alu_regfile_exec.sv
// ============================================================================
// Module  : alu_regfile_exec
// Brief   : Register file + operand mux + ALU with registered writeback.
//           Define ALU_MUL_EN to make alu_ctrl 111 an iterative multiply;
//           otherwise 111 is a single-cycle SLTU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int A0_INDEX   = 10
) (
    input wire logic         clk,
    input wire logic         rst,
    alu_regfile_exec_if.slave bus
);

    localparam int                  c_SH_W  = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_NREGS = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_alu_out;
    logic                  r_eq;
    logic                  r_out_valid;

    logic [DATA_WIDTH-1:0] w_rf_a;
    logic [DATA_WIDTH-1:0] w_rf_b;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic [c_SH_W-1:0]     w_shamt;
    logic                  w_eq;
    logic                  w_fire;

    logic                  w_wb_fire;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_wb_eq;
    logic [ADDR_WIDTH-1:0] w_wb_rd;
    logic                  w_wb_we;
    logic                  w_wb_addr_ok;

    // Register 0 and unpopulated addresses read as zero.
    always_comb begin
        w_rf_a = '0;
        w_rf_b = '0;
        if (bus.rs1 != '0 && {1'b0, bus.rs1} < c_NREGS) w_rf_a = r_regs[bus.rs1];
        if (bus.rs2 != '0 && {1'b0, bus.rs2} < c_NREGS) w_rf_b = r_regs[bus.rs2];
    end

    assign w_op_b  = bus.alu_src ? bus.imm_op : w_rf_b;
    assign w_shamt = w_op_b[c_SH_W-1:0];
    assign w_eq    = (w_rf_a == w_op_b);
    assign w_fire  = bus.in_valid && bus.in_ready;

    always_comb begin
        w_alu_res = '0;
        case (bus.alu_ctrl)
            3'b000: w_alu_res = w_rf_a + w_op_b;
            3'b001: w_alu_res = w_rf_a - w_op_b;
            3'b010: w_alu_res = w_rf_a & w_op_b;
            3'b011: w_alu_res = w_rf_a | w_op_b;
            3'b100: w_alu_res = w_rf_a ^ w_op_b;
            3'b101: w_alu_res = w_rf_a << w_shamt;
            3'b110: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_rf_a) < $signed(w_op_b))};
`ifdef ALU_MUL_EN
            default: w_alu_res = '0;
`else
            default: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (w_rf_a < w_op_b)};
`endif
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam logic [c_SH_W-1:0] c_CNT_LAST = c_SH_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_in_ready;
    logic [c_SH_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [ADDR_WIDTH-1:0] r_mul_rd;
    logic                  r_mul_we;
    logic                  r_mul_eq;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  w_start_mul;
    logic                  w_mul_done;

    assign w_start_mul = w_fire && (bus.alu_ctrl == 3'b111);
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (w_start_mul) w_state_next = S_MUL;
            end
            S_MUL: begin
                if (w_mul_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift-add: one multiplier bit per cycle, DATA_WIDTH cycles total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mul_rd <= '0;
            r_mul_we <= 1'b0;
            r_mul_eq <= 1'b0;
        end else if (w_start_mul) begin
            r_cnt    <= '0;
            r_mcand  <= w_rf_a;
            r_mplier <= w_op_b;
            r_acc    <= '0;
            r_mul_rd <= bus.rd;
            r_mul_we <= bus.we;
            r_mul_eq <= w_eq;
        end else if (r_state == S_MUL) begin
            r_cnt    <= r_cnt + 1'b1;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign w_wb_fire    = (w_fire && !w_start_mul) || w_mul_done;
    assign w_wb_data    = w_mul_done ? w_acc_next : w_alu_res;
    assign w_wb_eq      = w_mul_done ? r_mul_eq   : w_eq;
    assign w_wb_rd      = w_mul_done ? r_mul_rd   : bus.rd;
    assign w_wb_we      = w_mul_done ? r_mul_we   : bus.we;
`else
    assign bus.in_ready = 1'b1;
    assign w_wb_fire    = w_fire;
    assign w_wb_data    = w_alu_res;
    assign w_wb_eq      = w_eq;
    assign w_wb_rd      = bus.rd;
    assign w_wb_we      = bus.we;
`endif

    assign w_wb_addr_ok = (w_wb_rd != '0) && ({1'b0, w_wb_rd} < c_NREGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out   <= '0;
            r_eq        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_wb_fire;
            if (w_wb_fire) begin
                r_alu_out <= w_wb_data;
                r_eq      <= w_wb_eq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wb_fire && w_wb_we && w_wb_addr_ok) begin
            r_regs[w_wb_rd] <= w_wb_data;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.eq        = r_eq;
    assign bus.a0        = r_regs[A0_INDEX];

endmodule

`default_nettype wire
